regs_apb_master: RTL and testbench
==================================

REGS_APB_MASTER -- requirements
Module: regs_apb_master

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 16, the width of the command and APB address.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, the width of the command and APB data.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 255, the maximum ACCESS cycles before abort (range 1..65535).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-007 SHALL have cmd_write input 1: 1 = write, 0 = read.
REQ-008 SHALL have cmd_addr input ADDR_WIDTH, cmd_wdata input DATA_WIDTH, cmd_strb input DATA_WIDTH/8: the command payload.
REQ-009 SHALL have rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-010 SHALL have rsp_rdata output DATA_WIDTH, rsp_err output 1, rsp_timeout output 1: the response payload.
REQ-011 SHALL have psel, penable, pwrite outputs 1; paddr output ADDR_WIDTH; pwdata output DATA_WIDTH; pstrb output DATA_WIDTH/8: the APB requester side.
REQ-012 SHALL have prdata input DATA_WIDTH, pready input 1, pslverr input 1: the APB completer side.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-014 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-015 SHALL register cmd_write, cmd_addr, cmd_wdata and cmd_strb on acceptance and hold them on pwrite/paddr/pwdata/pstrb until the transfer ends.
REQ-016 SHALL drive pstrb to 0 for reads.
REQ-017 SHALL, for an aligned command (cmd_addr[1:0] == 0), go IDLE->SETUP: psel=1, penable=0 for exactly one cycle.
REQ-018 SHALL then go SETUP->ACCESS: psel=1, penable=1, holding while pready=0.
REQ-019 SHALL, when pready=1 is sampled in ACCESS, capture prdata (reads only, otherwise 0) into rsp_rdata and pslverr into rsp_err, deassert psel/penable next cycle, and enter RESP.
REQ-020 SHALL, for a misaligned command, perform no APB transfer (psel stays 0) and go IDLE->RESP with rsp_err=1, rsp_rdata=0, rsp_timeout=0.
REQ-021 SHALL assert rsp_valid only in RESP, holding the payload stable until rsp_ready=1, then return to IDLE.
REQ-022 SHALL give a zero-wait-state latency of 3 cycles: acceptance at edge N, SETUP N..N+1, ACCESS N+1..N+2, rsp_valid from N+3.
REQ-023 SHALL NOT accept a new command while rsp_valid=1; there is no overlap between response and next command.
REQ-024 SHALL ignore pready and pslverr outside ACCESS.

Reset
REQ-025 SHALL, while rst_n=0, immediately force psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, state=IDLE, timeout counter=0.
REQ-026 SHALL, on a reset asserted mid-transfer, abort the transfer and discard any pending response; no response is issued after reset release.
REQ-027 SHALL make cmd_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, when macro REGS_APB_TIMEOUT_EN is defined, include a counter cleared on entering ACCESS and incremented each ACCESS cycle with pready=0.
REQ-029 SHALL, with REGS_APB_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES: drop psel/penable next cycle, enter RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-030 SHALL give pready=1 priority over timeout when both occur in the same cycle.
REQ-031 SHALL, with REGS_APB_TIMEOUT_EN undefined, omit the counter, wait indefinitely in ACCESS, and tie rsp_timeout to 0.

Verification
REQ-032 SHALL cover: write addr 0x0004, wdata 0x00001234, strb 0xF, pready=1 -> one SETUP and one ACCESS cycle, paddr=0x0004, pwdata=0x00001234, rsp_valid at N+3, rsp_err=0.
REQ-033 SHALL cover: read addr 0x0008, pready low 3 ACCESS cycles, prdata=0x000000A5 -> ACCESS lasts 4 cycles, pstrb=0, rsp_rdata=0x000000A5, rsp_valid at N+6.
REQ-034 SHALL cover: write addr 0x0100 with pslverr=1 at completion -> rsp_err=1, rsp_timeout=0, FSM returns to IDLE after rsp_ready.
REQ-035 SHALL cover: read addr 0x0006 -> psel never asserted, rsp_err=1, rsp_rdata=0 at N+1.
REQ-036 SHALL cover: with REGS_APB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, pready held 0 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; without the macro -> psel remains 1 for 100+ cycles.
REQ-037 SHALL cover: rsp_ready low for 5 cycles, then rst_n pulsed low mid-ACCESS on the next command -> payload stable for 5 cycles, then all outputs 0 asynchronously and no response after reset.

Source files
------------

// File: rtl/regs_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : regs_apb_master
//  Purpose  : Converts a single-beat register command (valid/ready) into one
//             APB transfer and returns the result on a response channel.
//             Misaligned commands (addr[1:0] != 0) are rejected without any
//             bus activity.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             cmd_*                   - command channel (valid/ready + payload)
//             rsp_*                   - response channel (valid/ready + payload)
//             psel..pstrb             - APB requester outputs
//             prdata, pready, pslverr - APB completer inputs
//  Options  : REGS_APB_TIMEOUT_EN     - when defined, an ACCESS phase that sees
//                                       pready low for TIMEOUT_CYCLES cycles is
//                                       aborted with rsp_err=1, rsp_timeout=1.
//  Revision : 1.0 - initial release
// ============================================================================
module regs_apb_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_q,     state_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic                    pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q,     pstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic                    timeout_hit;
  logic                    rsp_to_d;

`ifdef REGS_APB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        rsp_to_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle without pready.
  assign timeout_hit = (state_q == ST_ACCESS) && !pready && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_SETUP) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !pready) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      rsp_to_q  <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_to_q  <= rsp_to_d;
    end
  end

  assign rsp_timeout = rsp_to_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef REGS_APB_TIMEOUT_EN
    rsp_to_d    = rsp_to_q;
`else
    rsp_to_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          if (cmd_addr[1:0] == 2'b00) begin
            state_d   = ST_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
          end else begin
            // Misaligned: answer immediately, bus stays quiet.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b0;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // pready is checked first so a completion wins over a timeout.
        if (pready) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          rsp_to_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Gated by rst_n so it is low during reset yet high in the very first
  // cycle after release, without waiting for a clock edge.
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_regs_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regs_apb_master
//  Purpose  : Directed self-checking bench for regs_apb_master.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regs_apb_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  regs_apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int            lat, n_setup, n_acc;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_wdata;
  logic [SW-1:0] seen_strb;
  logic          seen_write;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {56'd0, psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, rsp_timeout, 1'b0}, 64'd0);
    check({tag, "_paddr"}, {48'd0, paddr}, 64'd0);
    check({tag, "_pwdata"}, {32'd0, pwdata}, 64'd0);
    check({tag, "_pstrb"}, {60'd0, pstrb}, 64'd0);
    check({tag, "_rdata"}, {32'd0, rsp_rdata}, 64'd0);
  endtask

  // Issues one command (called just after a rising edge with the DUT idle)
  // and plays an APB completer that holds pready low for 'waits' ACCESS cycles.
  // lat = k where rsp_valid is first seen in the cycle ending at edge N+k.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input int waits, input logic slverr,
                         input logic [DW-1:0] rdata);
    check("cmd_ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    lat = 0; n_setup = 0; n_acc = 0;
    seen_addr = '0; seen_wdata = '0; seen_strb = '0; seen_write = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (psel && !penable) n_setup++;
      if (psel && penable) begin
        n_acc++;
        seen_addr = paddr; seen_wdata = pwdata; seen_strb = pstrb; seen_write = pwrite;
        if (n_acc > waits) begin
          pready = 1'b1; pslverr = slverr; prdata = rdata;
        end else begin
          pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
    end
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    if (lat == 0) check("rsp_valid_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_cleared"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, "_back_to_idle"}, {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    int found;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("cmd_ready_after_release", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;

    // Zero-wait write
    run_cmd(1'b1, 16'h0004, 32'h0000_1234, 4'hF, 0, 1'b0, 32'hFFFF_FFFF);
    check("wr_latency", lat, 3);
    check("wr_setup_cycles", n_setup, 1);
    check("wr_access_cycles", n_acc, 1);
    check("wr_paddr", {48'd0, seen_addr}, 64'h0004);
    check("wr_pwdata", {32'd0, seen_wdata}, 64'h1234);
    check("wr_pwrite", {63'd0, seen_write}, 64'd1);
    check("wr_pstrb", {60'd0, seen_strb}, 64'hF);
    check("wr_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("wr_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    check("wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("wr_psel_dropped", {62'd0, psel, penable}, 64'd0);
    finish_rsp("wr");

    // Read with three wait states
    run_cmd(1'b0, 16'h0008, 32'h5555_5555, 4'hF, 3, 1'b0, 32'h0000_00A5);
    check("rd_latency", lat, 6);
    check("rd_access_cycles", n_acc, 4);
    check("rd_pstrb", {60'd0, seen_strb}, 64'd0);
    check("rd_pwrite", {63'd0, seen_write}, 64'd0);
    check("rd_paddr", {48'd0, seen_addr}, 64'h0008);
    check("rd_rsp_rdata", {32'd0, rsp_rdata}, 64'hA5);
    check("rd_rsp_err", {63'd0, rsp_err}, 64'd0);
    finish_rsp("rd");

    // Write completing with slave error
    run_cmd(1'b1, 16'h0100, 32'hCAFE_0001, 4'h3, 0, 1'b1, 32'h0);
    check("slverr_latency", lat, 3);
    check("slverr_rsp_err", {63'd0, rsp_err}, 64'd1);
    check("slverr_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    finish_rsp("slverr");

    // Misaligned read
    run_cmd(1'b0, 16'h0006, 32'h0, 4'h0, 0, 1'b0, 32'h0);
    check("mis_latency", lat, 1);
    check("mis_no_bus", n_setup + n_acc, 0);
    check("mis_psel", {62'd0, psel, penable}, 64'd0);
    check("mis_rsp_err", {63'd0, rsp_err}, 64'd1);
    check("mis_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("mis_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    finish_rsp("mis");

`ifdef REGS_APB_TIMEOUT_EN
    // Completer never ready: abort after TO ACCESS cycles
    run_cmd(1'b0, 16'h0040, 32'h0, 4'h0, 1000, 1'b0, 32'h1);
    check("to_access_cycles", n_acc, TO);
    check("to_latency", lat, TO + 2);
    check("to_rsp_err", {63'd0, rsp_err}, 64'd1);
    check("to_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
    check("to_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    finish_rsp("to");
`else
    // No timeout: ACCESS holds for 121 cycles until pready arrives
    run_cmd(1'b0, 16'h0040, 32'h0, 4'h0, 120, 1'b0, 32'h0000_0777);
    check("long_access_cycles", n_acc, 121);
    check("long_latency", lat, 123);
    check("long_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    check("long_rsp_rdata", {32'd0, rsp_rdata}, 64'h777);
    finish_rsp("long");
`endif

    // Response back-pressure: payload stable while rsp_ready low
    run_cmd(1'b0, 16'h0010, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEEF);
    check("bp_latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_hold_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
      check("bp_hold_err", {63'd0, rsp_err}, 64'd0);
      check("bp_no_accept", {63'd0, cmd_ready}, 64'd0);
    end
    finish_rsp("bp");

    // Reset asserted in the middle of an ACCESS phase
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0020; cmd_wdata = 32'h1357_9BDF; cmd_strb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (psel && penable) begin
        found = 1;
        break;
      end
    end
    check("rst_mid_reached_access", found, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", {62'd0, rsp_valid, psel}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
